// File: rtl/order_pkg.sv
// Shared constants for the order message parser and its consumers.
// Holds field widths, frame geometry (40-byte frame, field byte offsets),
// message type codes, side codes, well-known symbol constants and the parser
// FSM state type.
package order_pkg;

  localparam int BYTE_W    = 8;
  localparam int SYM_W     = 48;
  localparam int PRICE_W   = 64;
  localparam int QTY_W     = 64;
  localparam int ID_W      = 32;
  localparam int MSGCNT_W  = 32;
  localparam int ERRCNT_W  = 16;
  localparam int FRAME_LEN = 40;
  localparam int IDX_W     = 6;

  // Byte offsets of each field inside the frame (first byte of the field).
  localparam logic [IDX_W-1:0] OFF_TYPE  = 6'd0;
  localparam logic [IDX_W-1:0] OFF_SYM   = 6'd1;
  localparam logic [IDX_W-1:0] OFF_SIDE  = 6'd7;
  localparam logic [IDX_W-1:0] OFF_PRICE = 6'd8;
  localparam logic [IDX_W-1:0] OFF_ORIG  = 6'd16;
  localparam logic [IDX_W-1:0] OFF_QTY   = 6'd24;
  localparam logic [IDX_W-1:0] OFF_OOID  = 6'd32;
  localparam logic [IDX_W-1:0] OFF_OID   = 6'd36;
  localparam logic [IDX_W-1:0] OFF_LAST  = 6'd39;

  localparam logic [BYTE_W-1:0] TYPE_ADD = 8'h41;  // 'A'
  localparam logic [BYTE_W-1:0] TYPE_MOD = 8'h4D;  // 'M'
  localparam logic [BYTE_W-1:0] SIDE_BID = 8'h42;  // 'B'
  localparam logic [BYTE_W-1:0] SIDE_ASK = 8'h53;  // 'S'

  // Symbols are ASCII, right-aligned and zero-padded in the 6-byte field.
  localparam logic [SYM_W-1:0] SYM_ABC  = 48'h0000_0041_4243;
  localparam logic [SYM_W-1:0] SYM_FOO  = 48'h0000_0046_4F4F;
  localparam logic [SYM_W-1:0] SYM_XYZ  = 48'h0000_0058_595A;
  localparam logic [SYM_W-1:0] SYM_BAR  = 48'h0000_0042_4152;
  localparam logic [SYM_W-1:0] SYM_MSFT = 48'h0000_4D53_4654;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIELDS = 2'd1,
    ST_EMIT   = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  function automatic logic is_type(input logic [BYTE_W-1:0] b);
    return (b == TYPE_ADD) || (b == TYPE_MOD);
  endfunction

  function automatic logic is_side(input logic [BYTE_W-1:0] b);
    return (b == SIDE_BID) || (b == SIDE_ASK);
  endfunction

endpackage

// File: rtl/order_msg_parser.sv
// Order message parser: decodes fixed 40-byte add/modify frames from a byte
// stream into a registered message bus for the order book.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   in_valid       stream byte valid
//   in_data[7:0]   stream byte (fields big-endian)
//   in_last        last byte of frame, qualified by in_valid
//   msg_valid      one-cycle pulse, decoded message on the output bus
//   msg_type       0 = add, 1 = modify
//   symbol_id[47:0], side (1 = bid), price/orig_price/quantity[63:0],
//   orig_order_id/order_id[31:0]   registered message fields
//   msg_count[31:0]  good messages emitted (wraps)
//   err_count[15:0]  dropped frames (saturates)
module order_msg_parser
  import order_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_last,
  output logic                msg_valid,
  output logic                msg_type,
  output logic [SYM_W-1:0]    symbol_id,
  output logic                side,
  output logic [PRICE_W-1:0]  price,
  output logic [PRICE_W-1:0]  orig_price,
  output logic [QTY_W-1:0]    quantity,
  output logic [ID_W-1:0]     orig_order_id,
  output logic [ID_W-1:0]     order_id,
  output logic [MSGCNT_W-1:0] msg_count,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              bad, bad_nxt;
  logic              err_inc;
  logic              emit_go;
  logic              shift_en;

  // Field shadow registers, filled byte by byte while the frame streams in.
  logic                   type_sh;
  logic [SYM_W-1:0]       sym_sh;
  logic                   side_sh;
  logic [PRICE_W-1:0]     price_sh;
  logic [PRICE_W-1:0]     orig_sh;
  logic [QTY_W-1:0]       qty_sh;
  logic [ID_W-1:0]        ooid_sh;
  logic [ID_W-BYTE_W-1:0] oid_sh;   // last order_id byte comes straight from in_data

  assign msg_valid = (state == ST_EMIT);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bad_nxt   = bad;
    err_inc   = 1'b0;
    emit_go   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      // EMIT behaves like IDLE so a byte arriving during the pulse starts
      // the next frame.
      ST_IDLE, ST_EMIT: begin
        state_nxt = ST_IDLE;
        if (in_valid) begin
          if (is_type(in_data)) begin
            if (in_last) begin
              err_inc = 1'b1;
            end else begin
              state_nxt = ST_FIELDS;
              idx_nxt   = IDX_W'(1);
              bad_nxt   = 1'b0;
              shift_en  = 1'b1;
            end
          end else begin
            err_inc   = 1'b1;
            state_nxt = in_last ? ST_IDLE : ST_SKIP;
          end
        end
      end
      ST_FIELDS: begin
        if (in_valid) begin
          shift_en = 1'b1;
          idx_nxt  = idx + 1'b1;
          if ((idx == OFF_SIDE) && !is_side(in_data)) bad_nxt = 1'b1;
          if (idx == OFF_LAST) begin
            idx_nxt = '0;
            if (!in_last) begin
              err_inc   = 1'b1;
              state_nxt = ST_SKIP;
            end else if (bad) begin
              err_inc   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              emit_go   = 1'b1;
              state_nxt = ST_EMIT;
            end
          end else if (in_last) begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end
        end
      end
      ST_SKIP: begin
        // The error for this frame was already counted on entry.
        if (in_valid && in_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      bad           <= 1'b0;
      msg_count     <= '0;
      err_count     <= '0;
      msg_type      <= 1'b0;
      symbol_id     <= '0;
      side          <= 1'b0;
      price         <= '0;
      orig_price    <= '0;
      quantity      <= '0;
      orig_order_id <= '0;
      order_id      <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      bad   <= bad_nxt;
      if (err_inc && (err_count != ERR_MAX)) err_count <= err_count + 1'b1;
      // Outputs load on the edge that accepts byte 39, so they are stable
      // for the whole msg_valid cycle.
      if (emit_go) begin
        msg_count     <= msg_count + 1'b1;
        msg_type      <= type_sh;
        symbol_id     <= sym_sh;
        side          <= side_sh;
        price         <= price_sh;
        orig_price    <= orig_sh;
        quantity      <= qty_sh;
        orig_order_id <= ooid_sh;
        order_id      <= {oid_sh, in_data};
      end
    end
  end

  // Shadow registers need no reset: they are only observed through emit_go,
  // which requires a complete frame after reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      if (state != ST_FIELDS)    type_sh  <= (in_data == TYPE_MOD);
      else if (idx < OFF_SIDE)   sym_sh   <= {sym_sh[SYM_W-BYTE_W-1:0], in_data};
      else if (idx == OFF_SIDE)  side_sh  <= (in_data == SIDE_BID);
      else if (idx < OFF_ORIG)   price_sh <= {price_sh[PRICE_W-BYTE_W-1:0], in_data};
      else if (idx < OFF_QTY)    orig_sh  <= {orig_sh[PRICE_W-BYTE_W-1:0], in_data};
      else if (idx < OFF_OOID)   qty_sh   <= {qty_sh[QTY_W-BYTE_W-1:0], in_data};
      else if (idx < OFF_OID)    ooid_sh  <= {ooid_sh[ID_W-BYTE_W-1:0], in_data};
      else                       oid_sh   <= {oid_sh[ID_W-2*BYTE_W-1:0], in_data};
    end
  end

endmodule

// File: doc/order_msg_parser.md
ORDER_MSG_PARSER -- requirements
Module: order_msg_parser

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-004 SHALL have port in_data  input  8  stream byte, message fields big-endian.
REQ-005 SHALL have port in_last  input  1  marks final byte of a frame; sampled only with in_valid.
REQ-006 SHALL have port msg_valid  output  1  one-cycle pulse, decoded message present.
REQ-007 SHALL have port msg_type  output  1  0 = add ('A', 0x41), 1 = modify ('M', 0x4D).
REQ-008 SHALL have ports symbol_id  output  48; side  output  1 (1 = bid 'B', 0 = ask 'S').
REQ-009 SHALL have ports price, orig_price, quantity  output  64 each.
REQ-010 SHALL have ports orig_order_id, order_id  output  32 each.
REQ-011 SHALL have ports msg_count  output  32 (good messages, wraps) and err_count  output  16 (dropped frames, saturates at 0xFFFF).

Function
REQ-012 SHALL parse a fixed 40-byte frame: [0] type, [1:6] symbol, [7] side, [8:15] price, [16:23] orig_price, [24:31] quantity, [32:35] orig_order_id, [36:39] order_id.
REQ-013 SHALL implement FSM states IDLE, FIELDS, EMIT, SKIP; reset state IDLE.
REQ-014 IDLE: valid byte 0x41/0x4D -> FIELDS, byte index = 1; any other byte -> SKIP (err_count +1), or stay IDLE if that byte has in_last.
REQ-015 FIELDS: each valid byte shifts into its field register, index +1; cycles with in_valid=0 hold all state (gaps allowed anywhere).
REQ-016 byte 7 not 0x42/0x53 SHALL mark frame bad; frame still consumed to in_last, then dropped.
REQ-017 in_last on byte index < 39 (runt) SHALL drop frame, err_count +1, -> IDLE.
REQ-018 byte 39 with in_last and frame good -> EMIT; byte 39 with in_last and frame bad -> IDLE, err_count +1.
REQ-019 byte 39 without in_last (oversize) -> SKIP, err_count +1, no msg_valid.
REQ-020 SKIP: discard bytes until valid byte with in_last, then -> IDLE.
REQ-021 EMIT: msg_valid = 1 for exactly one cycle, msg_count +1, -> IDLE; latency = 1 cycle after last byte accepted.
REQ-022 A byte presented during EMIT SHALL be processed as byte 0 of the next frame (no byte lost; back-to-back frames supported at 1 byte/cycle).
REQ-023 Output message fields SHALL be registered, updated only on EMIT, and hold value otherwise.
REQ-024 Each frame SHALL increment err_count at most once.
REQ-025 in_valid=1 at index 0 with in_last=1 and valid type SHALL count as runt (REQ-017).

Reset
REQ-026 rst_n=0 at a clock edge SHALL force state IDLE, index 0, bad flag 0, msg_valid 0, all field outputs 0, msg_count 0, err_count 0.
REQ-027 Reset mid-frame SHALL discard the partial frame without error count; the next valid byte is treated as byte 0.
REQ-028 Reset SHALL dominate all other inputs in the same cycle.

Structure
REQ-029 Shared package order_pkg SHALL hold field widths, frame length (40), byte offsets, type codes (0x41, 0x4D), side codes (0x42, 0x53) and symbol constants (ABC, FOO, XYZ, BAR, MSFT).
REQ-030 Block SHALL be a single module; no sub-module; output bus SHALL directly drive the order book message inputs.

Verification
REQ-031 Add frame: 'A', "ABC", 'B', price 0x64, qty 0x0A, order_id 7, contiguous -> one msg_valid 1 cycle after byte 39, msg_type 0, symbol_id 0x000000414243, side 1, msg_count 1.
REQ-032 Two back-to-back 40-byte modify frames, no idle cycle -> two msg_valid pulses 40 cycles apart, second carries orig_order_id and order_id of frame 2, msg_count 2.
REQ-033 Runt frame of 20 bytes, then good frame -> no pulse for runt, err_count 1, good frame decoded correctly.
REQ-034 Frame with type 0x58 and 41-byte oversize frame -> no pulses, err_count 2, state IDLE afterwards.
REQ-035 Good frame with random in_valid gaps, and rst_n low at byte 25 of a second frame -> first frame decoded intact; after reset all outputs 0, next good frame decoded, err_count 0.
REQ-036 0x10000 bad frames -> err_count saturates at 0xFFFF.
